// File: rtl/lsmitll_toggle_deserializer.sv
// Sampling-clock deserializer for toggle-encoded RSFQ outputs: turns level edges
// into events, assigns one bit per SFQ clock period and assembles WIDTH-bit words.
module lsmitll_toggle_deserializer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sfq_clk_in,
  input  logic             sfq_din,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic [CNT_W-1:0] pulse_count,
  output logic             err_setup,
  output logic             err_overrun,
  output logic             err_unknown
);
  localparam int BW = $clog2(WIDTH);
  localparam int SW = $clog2(SETUP_CYC + 2);

  // Index 0 carries the SFQ clock, index 1 the SFQ data.
  logic [1:0] raw;
  logic [1:0] s1_reg, s2_reg, s3_reg;
  logic [1:0] unk, ev;
  logic [1:0] prime_reg;
  logic       primed;

  assign raw    = {sfq_din, sfq_clk_in};
  assign primed = (prime_reg == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      assign unk[gi] = (s2_reg[gi] !== 1'b0) && (s2_reg[gi] !== 1'b1);
      assign ev[gi]  = primed && !unk[gi] && (s2_reg[gi] ^ s3_reg[gi]);

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg[gi] <= 1'b0;
          s2_reg[gi] <= 1'b0;
          s3_reg[gi] <= 1'b0;
        end else begin
          s1_reg[gi] <= raw[gi];
          s2_reg[gi] <= s1_reg[gi];
          // An unknown sample leaves history untouched so it cannot fake an edge later.
          if (!unk[gi]) s3_reg[gi] <= s2_reg[gi];
        end
      end
    end
  endgenerate

  logic             c_ev, d_ev;
  logic             pending_reg;
  logic [BW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [SW-1:0]    since_data_reg;
  logic             seen_data_reg;
  logic             setup_viol;

  assign c_ev = ev[0];
  assign d_ev = ev[1];

  always_comb begin
    shift_next = {pending_reg, shift_reg[WIDTH-1:1]};
    setup_viol = 1'b0;
    if (SETUP_CYC > 0)
      setup_viol = d_ev || (seen_data_reg && (since_data_reg < SW'(SETUP_CYC)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prime_reg      <= 2'd0;
      pending_reg    <= 1'b0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      since_data_reg <= '0;
      seen_data_reg  <= 1'b0;
      word_out       <= '0;
      word_valid     <= 1'b0;
      pulse_count    <= '0;
      err_setup      <= 1'b0;
      err_overrun    <= 1'b0;
      err_unknown    <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (!primed) prime_reg <= prime_reg + 2'd1;
      if (|unk) err_unknown <= 1'b1;

      if (c_ev) begin
        shift_reg <= shift_next;
        if (setup_viol) err_setup <= 1'b1;
        if (bit_cnt_reg == BW'(WIDTH - 1)) begin
          bit_cnt_reg <= '0;
          word_out    <= shift_next;
          word_valid  <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end

      // A coincident clock closes the slot with the old pending; data then opens the next.
      if (d_ev) pending_reg <= 1'b1;
      else if (c_ev) pending_reg <= 1'b0;
      if (d_ev && pending_reg && !c_ev) err_overrun <= 1'b1;

      if (d_ev) begin
        if (pulse_count != '1) pulse_count <= pulse_count + 1'b1;
        since_data_reg <= '0;
        seen_data_reg  <= 1'b1;
      end else if (since_data_reg < SW'(SETUP_CYC)) begin
        since_data_reg <= since_data_reg + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lsmitll_toggle_deserializer.sv
// Directed bench for lsmitll_toggle_deserializer (WIDTH=8, SETUP_CYC=2, CNT_W=16).
module tb_lsmitll_toggle_deserializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sfq_clk_in = 1'b1;
  logic        sfq_din = 1'b1;
  logic [7:0]  word_out;
  logic        word_valid;
  logic [15:0] pulse_count;
  logic        err_setup, err_overrun, err_unknown;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  logic probe;
  logic exp_unk;

  lsmitll_toggle_deserializer #(.WIDTH(8), .SETUP_CYC(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sfq_clk_in(sfq_clk_in), .sfq_din(sfq_din),
    .word_out(word_out), .word_valid(word_valid), .pulse_count(pulse_count),
    .err_setup(err_setup), .err_overrun(err_overrun), .err_unknown(err_unknown)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (word_valid === 1'b1) valid_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each slot: optional data toggle, 5 cycles, clock toggle, 5 cycles.
  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (bits[i]) sfq_din = ~sfq_din;
      tick(5);
      sfq_clk_in = ~sfq_clk_in;
      tick(5);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(10);
    $display("reset with inputs high: valid=%0d count=%0d", word_valid, pulse_count);
    chk("reset_valid", 64'(word_valid), 64'd0);
    chk("reset_count", 64'(pulse_count), 64'd0);
    chk("reset_word", 64'(word_out), 64'd0);
    chk("reset_errs", 64'({err_setup, err_overrun, err_unknown}), 64'd0);
    chk("reset_no_valid", 64'(valid_cnt), 64'd0);

    send_bits(8'b1000_1101, 8);
    $display("clean word: word=%0h count=%0d valids=%0d", word_out, pulse_count, valid_cnt);
    chk("clean_word", 64'(word_out), 64'h8D);
    chk("clean_valid_once", 64'(valid_cnt), 64'd1);
    chk("clean_count", 64'(pulse_count), 64'd4);
    chk("clean_errs", 64'({err_setup, err_overrun, err_unknown}), 64'd0);

    sfq_din = ~sfq_din;
    tick(4);
    sfq_din = ~sfq_din;
    tick(5);
    sfq_clk_in = ~sfq_clk_in;
    tick(5);
    send_bits(8'h00, 7);
    $display("overrun word: word=%0h count=%0d ovr=%0d", word_out, pulse_count, err_overrun);
    chk("ovr_flag", 64'(err_overrun), 64'd1);
    chk("ovr_word", 64'(word_out), 64'h01);
    chk("ovr_count", 64'(pulse_count), 64'd6);
    chk("ovr_no_setup", 64'(err_setup), 64'd0);
    chk("ovr_valids", 64'(valid_cnt), 64'd2);

    sfq_din = ~sfq_din;
    sfq_clk_in = ~sfq_clk_in;
    tick(5);
    send_bits(8'h00, 7);
    $display("simultaneous word: word=%0h setup=%0d", word_out, err_setup);
    chk("sim_setup", 64'(err_setup), 64'd1);
    chk("sim_word", 64'(word_out), 64'h02);
    chk("sim_count", 64'(pulse_count), 64'd7);
    chk("sim_ovr_sticky", 64'(err_overrun), 64'd1);

    probe = 1'bx;
    exp_unk = (probe !== 1'b0) && (probe !== 1'b1);
    sfq_din = 1'bx;
    tick(1);
    sfq_din = 1'b0;
    tick(5);
    send_bits(8'h3C, 8);
    $display("after unknown: word=%0h unk=%0d", word_out, err_unknown);
    chk("unk_flag", 64'(err_unknown), 64'(exp_unk));
    chk("unk_word", 64'(word_out), 64'h3C);
    chk("unk_valids", 64'(valid_cnt), 64'd4);
    do_reset();
    tick(1);
    $display("after rst: errs=%0b count=%0d", {err_setup, err_overrun, err_unknown}, pulse_count);
    chk("rst_errs", 64'({err_setup, err_overrun, err_unknown}), 64'd0);
    chk("rst_count", 64'(pulse_count), 64'd0);

    tick(5);
    valid_cnt = 0;
    send_bits(8'h1F, 5);
    do_reset();
    tick(5);
    chk("midword_no_valid", 64'(valid_cnt), 64'd0);
    send_bits(8'hA5, 8);
    $display("after mid-word reset: word=%0h valids=%0d count=%0d", word_out, valid_cnt, pulse_count);
    chk("midword_word", 64'(word_out), 64'hA5);
    chk("midword_valids", 64'(valid_cnt), 64'd1);
    chk("midword_count", 64'(pulse_count), 64'd4);
    chk("midword_errs", 64'({err_setup, err_overrun, err_unknown}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
